// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures the live time on MODE, edits hour then minute in BCD with INC,
// and pulses the counter preset enables for one cycle. The edit is aborted after an idle timeout.
module time_set_ctrl #(
    parameter int TIMEOUT_CYC = 10_000_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       CR,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    output logic [7:0] pre_hour,
    output logic [7:0] pre_min,
    output logic       PE_hour,
    output logic       PE_min,
    output logic       run_en,
    output logic       blink_h,
    output logic       blink_m
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET_H,
        ST_SET_M,
        ST_LOAD
    } state_t;

    state_t        state_q,     state_d;
    logic          btn_mode_q;
    logic          btn_inc_q;
    logic [7:0]    pre_hour_q,  pre_hour_d;
    logic [7:0]    pre_min_q,   pre_min_d;
    logic [TW-1:0] tmo_q,       tmo_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q,     phase_d;
    logic          pe_q,        pe_d;
    logic          run_en_q,    run_en_d;
    logic          blink_h_q,   blink_h_d;
    logic          blink_m_q,   blink_m_d;

    logic rise_mode;
    logic rise_inc;

    assign rise_mode = btn_mode & ~btn_mode_q;
    assign rise_inc  = btn_inc  & ~btn_inc_q;

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] top);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= top);
    endfunction

    // Values are always valid BCD here, so a plain byte compare detects the wrap point.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d     = state_q;
        pre_hour_d  = pre_hour_q;
        pre_min_d   = pre_min_q;
        tmo_d       = tmo_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        case (state_q)
            ST_RUN: begin
                if (rise_mode) begin
                    state_d    = ST_SET_H;
                    pre_hour_d = bcd_valid(cur_hour, 8'h23) ? cur_hour : 8'h00;
                    pre_min_d  = bcd_valid(cur_min,  8'h59) ? cur_min  : 8'h00;
                    tmo_d      = '0;
                end
            end
            ST_SET_H, ST_SET_M: begin
                if (rise_mode) begin
                    state_d = (state_q == ST_SET_H) ? ST_SET_M : ST_LOAD;
                    tmo_d   = '0;
                end else if (rise_inc) begin
                    if (state_q == ST_SET_H) begin
                        pre_hour_d = bcd_inc(pre_hour_q, 8'h23);
                    end else begin
                        pre_min_d = bcd_inc(pre_min_q, 8'h59);
                    end
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end

                if (blink_cnt_q == BLK_LAST) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Blink phase restarts on every new edit session and is idle outside the edit states.
        if ((state_q == ST_RUN) || (state_d == ST_RUN) || (state_d == ST_LOAD)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end

        pe_d      = (state_d == ST_LOAD);
        run_en_d  = (state_d == ST_RUN);
        blink_h_d = phase_d & (state_d == ST_SET_H);
        blink_m_d = phase_d & (state_d == ST_SET_M);
    end

    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            state_q     <= ST_RUN;
            btn_mode_q  <= 1'b0;
            btn_inc_q   <= 1'b0;
            pre_hour_q  <= 8'h00;
            pre_min_q   <= 8'h00;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pe_q        <= 1'b0;
            run_en_q    <= 1'b1;
            blink_h_q   <= 1'b0;
            blink_m_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_mode_q  <= btn_mode;
            btn_inc_q   <= btn_inc;
            pre_hour_q  <= pre_hour_d;
            pre_min_q   <= pre_min_d;
            tmo_q       <= tmo_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pe_q        <= pe_d;
            run_en_q    <= run_en_d;
            blink_h_q   <= blink_h_d;
            blink_m_q   <= blink_m_d;
        end
    end

    assign pre_hour = pre_hour_q;
    assign pre_min  = pre_min_q;
    assign PE_hour  = pe_q;
    assign PE_min   = pe_q;
    assign run_en   = run_en_q;
    assign blink_h  = blink_h_q;
    assign blink_m  = blink_m_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: vector table, hand-written corner sequences, then random stimulus
// against a decimal-arithmetic reference model.
module tb_time_set_ctrl;

    localparam int TMO = 16;
    localparam int BLK = 4;

    logic       clk = 1'b0;
    logic       CR;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] pre_hour;
    logic [7:0] pre_min;
    logic       PE_hour;
    logic       PE_min;
    logic       run_en;
    logic       blink_h;
    logic       blink_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .TIMEOUT_CYC(TMO),
        .BLINK_DIV  (BLK)
    ) dut (
        .clk     (clk),
        .CR      (CR),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .cur_hour(cur_hour),
        .cur_min (cur_min),
        .pre_hour(pre_hour),
        .pre_min (pre_min),
        .PE_hour (PE_hour),
        .PE_min  (PE_min),
        .run_en  (run_en),
        .blink_h (blink_h),
        .blink_m (blink_m)
    );

    // Reference model: mode 0=run 1=edit hour 2=edit minute 3=load; time held as plain integers.
    int m_mode, m_hour, m_min, m_idle, m_setcyc;
    bit m_pm, m_pi;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [7:0] b, input int lim);
        int v;
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 0;
        v = 10 * int'(b[7:4]) + int'(b[3:0]);
        return (v > lim) ? 0 : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hour = 0; m_min = 0; m_idle = 0; m_setcyc = 0; m_pm = 0; m_pi = 0;
    endtask

    task automatic model_step(input logic m, input logic i, input logic [7:0] ch, input logic [7:0] cm);
        bit rm, ri;
        rm = m && !m_pm;
        ri = i && !m_pi;
        m_pm = m;
        m_pi = i;
        case (m_mode)
            0: if (rm) begin
                m_mode = 1; m_hour = from_bcd(ch, 23); m_min = from_bcd(cm, 59);
                m_idle = 0; m_setcyc = 0;
            end
            1, 2: begin
                m_setcyc++;
                if (rm) begin
                    m_mode = m_mode + 1; m_idle = 0;
                end else if (ri) begin
                    if (m_mode == 1) m_hour = (m_hour + 1) % 24;
                    else             m_min  = (m_min + 1) % 60;
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle >= TMO) m_mode = 0;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input logic m, input logic i, input logic [7:0] ch, input logic [7:0] cm);
        @(negedge clk);
        btn_mode = m; btn_inc = i; cur_hour = ch; cur_min = cm;
        @(posedge clk);
        model_step(m, i, ch, cm);
        #1;
    endtask

    task automatic chk_model();
        bit ph;
        ph = ((m_setcyc / BLK) % 2) == 1;
        chk8("rnd_pre_hour", pre_hour, to_bcd(m_hour));
        chk8("rnd_pre_min",  pre_min,  to_bcd(m_min));
        chk1("rnd_PE_hour",  PE_hour,  m_mode == 3);
        chk1("rnd_PE_min",   PE_min,   m_mode == 3);
        chk1("rnd_run_en",   run_en,   m_mode == 0);
        chk1("rnd_blink_h",  blink_h,  ph && m_mode == 1);
        chk1("rnd_blink_m",  blink_m,  ph && m_mode == 2);
    endtask

    typedef struct {
        logic [1:0] btn;   // {mode, inc}
        logic [7:0] ch, cm;
        logic [7:0] ph, pm;
        logic [3:0] flg;   // {PE, run_en, blink_h, blink_m}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] b, input logic [7:0] ch, input logic [7:0] cm,
                       input logic [7:0] ph, input logic [7:0] pm, input logic [3:0] f);
        vec_t v;
        v.btn = b; v.ch = ch; v.cm = cm; v.ph = ph; v.pm = pm; v.flg = f;
        tbl.push_back(v);
    endtask

    initial begin
        bit pe_seen;
        logic [7:0] rh, rm8;
        CR = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; cur_hour = 8'h00; cur_min = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk8("reset_pre_hour", pre_hour, 8'h00);
        chk8("reset_pre_min",  pre_min,  8'h00);
        chk1("reset_PE",       PE_hour | PE_min, 1'b0);
        chk1("reset_run_en",   run_en,   1'b1);
        chk1("reset_blink",    blink_h | blink_m, 1'b0);
        @(negedge clk); CR = 1'b0;

        // Full set 12:34 -> 15:36, wrap from 23:59, INC ignored in RUN.
        add(2'b10, 8'h12, 8'h34, 8'h12, 8'h34, 4'b0000);
        add(2'b00, 8'h12, 8'h34, 8'h12, 8'h34, 4'b0000);
        add(2'b01, 8'h12, 8'h34, 8'h13, 8'h34, 4'b0000);
        add(2'b00, 8'h12, 8'h34, 8'h13, 8'h34, 4'b0000);
        add(2'b01, 8'h12, 8'h34, 8'h14, 8'h34, 4'b0010);
        add(2'b00, 8'h12, 8'h34, 8'h14, 8'h34, 4'b0010);
        add(2'b01, 8'h12, 8'h34, 8'h15, 8'h34, 4'b0010);
        add(2'b00, 8'h12, 8'h34, 8'h15, 8'h34, 4'b0010);
        add(2'b10, 8'h12, 8'h34, 8'h15, 8'h34, 4'b0000);
        add(2'b00, 8'h12, 8'h34, 8'h15, 8'h34, 4'b0000);
        add(2'b01, 8'h12, 8'h34, 8'h15, 8'h35, 4'b0000);
        add(2'b00, 8'h12, 8'h34, 8'h15, 8'h35, 4'b0000);
        add(2'b01, 8'h12, 8'h34, 8'h15, 8'h36, 4'b0001);
        add(2'b00, 8'h12, 8'h34, 8'h15, 8'h36, 4'b0001);
        add(2'b10, 8'h12, 8'h34, 8'h15, 8'h36, 4'b1000);
        add(2'b00, 8'h12, 8'h34, 8'h15, 8'h36, 4'b0100);
        add(2'b00, 8'h12, 8'h34, 8'h15, 8'h36, 4'b0100);
        add(2'b10, 8'h23, 8'h59, 8'h23, 8'h59, 4'b0000);
        add(2'b00, 8'h23, 8'h59, 8'h23, 8'h59, 4'b0000);
        add(2'b01, 8'h23, 8'h59, 8'h00, 8'h59, 4'b0000);
        add(2'b00, 8'h23, 8'h59, 8'h00, 8'h59, 4'b0000);
        add(2'b10, 8'h23, 8'h59, 8'h00, 8'h59, 4'b0001);
        add(2'b00, 8'h23, 8'h59, 8'h00, 8'h59, 4'b0001);
        add(2'b01, 8'h23, 8'h59, 8'h00, 8'h00, 4'b0001);
        add(2'b00, 8'h23, 8'h59, 8'h00, 8'h00, 4'b0001);
        add(2'b10, 8'h23, 8'h59, 8'h00, 8'h00, 4'b1000);
        add(2'b00, 8'h23, 8'h59, 8'h00, 8'h00, 4'b0100);
        add(2'b01, 8'h23, 8'h59, 8'h00, 8'h00, 4'b0100);
        add(2'b00, 8'h23, 8'h59, 8'h00, 8'h00, 4'b0100);

        foreach (tbl[k]) begin
            tick(tbl[k].btn[1], tbl[k].btn[0], tbl[k].ch, tbl[k].cm);
            $display("vec %0d: btn=%b pre=%h:%h PE=%b run=%b blink=%b%b", k, tbl[k].btn,
                     pre_hour, pre_min, PE_hour, run_en, blink_h, blink_m);
            chk8("vec_pre_hour", pre_hour, tbl[k].ph);
            chk8("vec_pre_min",  pre_min,  tbl[k].pm);
            chk1("vec_PE_hour",  PE_hour,  tbl[k].flg[3]);
            chk1("vec_PE_min",   PE_min,   tbl[k].flg[3]);
            chk1("vec_run_en",   run_en,   tbl[k].flg[2]);
            chk1("vec_blink_h",  blink_h,  tbl[k].flg[1]);
            chk1("vec_blink_m",  blink_m,  tbl[k].flg[0]);
        end

        // Ten INC presses in minute edit: 05 -> 15.
        tick(1'b1, 1'b0, 8'h00, 8'h05);
        tick(1'b0, 1'b0, 8'h00, 8'h05);
        tick(1'b1, 1'b0, 8'h00, 8'h05);
        tick(1'b0, 1'b0, 8'h00, 8'h05);
        for (int n = 0; n < 10; n++) begin
            tick(1'b0, 1'b1, 8'h00, 8'h05);
            tick(1'b0, 1'b0, 8'h00, 8'h05);
        end
        $display("inc10: pre_min=%h", pre_min);
        chk8("inc10_pre_min", pre_min, 8'h15);
        tick(1'b1, 1'b0, 8'h00, 8'h05);
        chk1("inc10_load_PE", PE_hour & PE_min, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 8'h05);
        chk1("inc10_back_run", run_en, 1'b1);

        // MODE and INC on the same edge in hour edit, then a held INC.
        tick(1'b1, 1'b0, 8'h10, 8'h20);
        tick(1'b0, 1'b0, 8'h10, 8'h20);
        tick(1'b1, 1'b1, 8'h10, 8'h20);
        chk8("same_edge_pre_hour", pre_hour, 8'h10);
        tick(1'b0, 1'b0, 8'h10, 8'h20);
        tick(1'b0, 1'b1, 8'h10, 8'h20);
        chk8("same_edge_now_min", pre_min, 8'h21);
        chk8("same_edge_hour_kept", pre_hour, 8'h10);
        pe_seen = 1'b0;
        for (int n = 0; n < 13; n++) begin
            tick(1'b0, 1'b1, 8'h10, 8'h20);
            pe_seen = pe_seen | PE_hour | PE_min;
        end
        $display("held_inc: pre_min=%h run_en=%b", pre_min, run_en);
        chk8("held_inc_once", pre_min, 8'h21);
        chk1("held_inc_still_edit", run_en, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick(1'b0, 1'b1, 8'h10, 8'h20);
            pe_seen = pe_seen | PE_hour | PE_min;
        end
        chk1("held_inc_timeout_run", run_en, 1'b1);
        chk1("held_inc_no_PE", pe_seen, 1'b0);
        tick(1'b0, 1'b0, 8'h10, 8'h20);

        // Invalid hour capture and blink cadence.
        tick(1'b1, 1'b0, 8'h2A, 8'h45);
        $display("invalid: pre=%h:%h", pre_hour, pre_min);
        chk8("invalid_hour_2A", pre_hour, 8'h00);
        chk8("invalid_min_ok",  pre_min,  8'h45);
        for (int n = 1; n <= 8; n++) begin
            tick(1'b0, 1'b0, 8'h2A, 8'h45);
            chk1("blink_h_phase", blink_h, (n >= 4) && (n < 8));
        end
        tick(1'b1, 1'b0, 8'h2A, 8'h45);
        tick(1'b0, 1'b0, 8'h2A, 8'h45);
        chk1("pre_reset_in_edit", run_en, 1'b0);

        // Asynchronous reset in the middle of a cycle while editing minutes.
        @(negedge clk); #2; CR = 1'b1; #1;
        model_reset();
        $display("async_reset: pre=%h:%h PE=%b run=%b", pre_hour, pre_min, PE_hour, run_en);
        chk8("areset_pre_hour", pre_hour, 8'h00);
        chk8("areset_pre_min",  pre_min,  8'h00);
        chk1("areset_PE",       PE_hour | PE_min, 1'b0);
        chk1("areset_run_en",   run_en,   1'b1);
        chk1("areset_blink",    blink_h | blink_m, 1'b0);
        @(negedge clk); CR = 1'b0;

        // Out-of-range captures, then idle timeout.
        tick(1'b1, 1'b0, 8'h24, 8'h60);
        chk8("invalid_hour_24", pre_hour, 8'h00);
        chk8("invalid_min_60",  pre_min,  8'h00);
        pe_seen = 1'b0;
        for (int n = 1; n <= TMO; n++) begin
            tick(1'b0, 1'b0, 8'h24, 8'h60);
            pe_seen = pe_seen | PE_hour | PE_min;
            chk1("timeout_run_en", run_en, n == TMO);
        end
        $display("timeout: run_en=%b pe_seen=%b", run_en, pe_seen);
        chk1("timeout_no_PE", pe_seen, 1'b0);
        tick(1'b1, 1'b0, 8'h19, 8'h5A);
        chk8("valid_hour_19",  pre_hour, 8'h19);
        chk8("invalid_min_5A", pre_min,  8'h00);
        tick(1'b0, 1'b0, 8'h19, 8'h5A);
        tick(1'b1, 1'b0, 8'h19, 8'h5A);
        tick(1'b0, 1'b0, 8'h19, 8'h5A);
        tick(1'b1, 1'b0, 8'h19, 8'h5A);
        tick(1'b0, 1'b0, 8'h19, 8'h5A);

        // Random stimulus against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rh  = ($urandom_range(0, 1) == 1) ? to_bcd(int'($urandom_range(0, 23))) : 8'($urandom);
            rm8 = ($urandom_range(0, 1) == 1) ? to_bcd(int'($urandom_range(0, 59))) : 8'($urandom);
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, rh, rm8);
            chk_model();
        end
        $display("random: done, model mode=%0d pre=%h:%h", m_mode, pre_hour, pre_min);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
